// File: rtl/vsim_chan_mux.sv
// vsim_chan_mux: many-to-one send path toward the simulator endpoint.
// Each user channel has its own small FIFO. A round-robin arbiter picks a
// non-empty FIFO, and the chosen word goes into one registered host-side
// enq port together with the index of the channel it came from.
module vsim_chan_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int TAGW     = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CHANNELS-1:0]       in_enq__ENA,
  input  logic [CHANNELS*WIDTH-1:0] in_enq_v,
  output logic [CHANNELS-1:0]       in_enq__RDY,
  output logic                      out_enq__ENA,
  output logic [WIDTH-1:0]          out_enq_v,
  output logic [TAGW-1:0]           out_enq_tag,
  input  logic                      out_enq__RDY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  generate
    if (TAGW != $clog2(CHANNELS)) begin : g_bad_tagw
      $error("vsim_chan_mux: TAGW must equal clog2(CHANNELS)");
    end
    if (CHANNELS < 2) begin : g_bad_channels
      $error("vsim_chan_mux: CHANNELS must be at least 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("vsim_chan_mux: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
  logic [PW-1:0]       rd_ptr [CHANNELS];
  logic [PW-1:0]       wr_ptr [CHANNELS];
  logic [CW-1:0]       count  [CHANNELS];

  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;

  // Ready is held low until the first edge after reset is released.
  logic                rdy_en;
  logic [TAGW-1:0]     rr;
  logic [TAGW-1:0]     grant;
  logic                any_valid;
  logic                load;
  logic [WIDTH-1:0]    head;

  // Adds an offset to a channel index, wrapping modulo CHANNELS. The offset
  // is never more than CHANNELS, so a single subtract is enough.
  function automatic logic [TAGW-1:0] wrap_idx(input logic [TAGW-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return TAGW'(s);
  endfunction

  // Per-channel status and handshakes. A full FIFO stays not-ready even in
  // a cycle where it is also being popped, so there is no bypass path.
  always_comb begin
    nonempty    = '0;
    full        = '0;
    in_enq__RDY = '0;
    push        = '0;
    pop         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      nonempty[i]    = (count[i] != '0);
      full[i]        = (count[i] == CW'(DEPTH));
      in_enq__RDY[i] = rdy_en & ~full[i];
      push[i]        = in_enq__ENA[i] & in_enq__RDY[i];
      pop[i]         = load && (grant == TAGW'(i));
    end
  end

  // Round-robin grant: the first non-empty channel after the last grant.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!any_valid && nonempty[wrap_idx(rr, k)]) begin
        any_valid = 1'b1;
        grant     = wrap_idx(rr, k);
      end
    end
  end

  // The output register loads when it is empty or draining this cycle.
  always_comb begin
    load = (!out_enq__ENA || out_enq__RDY) && any_valid;
    head = mem[grant][rd_ptr[grant]];
  end

  // FIFO storage. It has no reset because validity is tracked by count.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_enq_v[i*WIDTH +: WIDTH];
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Input-ready enable. It goes high on the first edge after reset release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Host-side output register and the round-robin pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_enq__ENA <= 1'b0;
      out_enq_v    <= '0;
      out_enq_tag  <= '0;
      rr           <= TAGW'(CHANNELS - 1);
    end else if (!out_enq__ENA || out_enq__RDY) begin
      if (any_valid) begin
        out_enq__ENA <= 1'b1;
        out_enq_v    <= head;
        out_enq_tag  <= grant;
        rr           <= grant;
      end else begin
        out_enq__ENA <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vsim_chan_mux.sv
// Testbench for vsim_chan_mux with 4 channels of 32 bits and a FIFO depth of 4.
module tb_vsim_chan_mux;

  logic         CLK;
  logic         nRST;
  logic [3:0]   in_enq__ENA;
  logic [127:0] in_enq_v;
  logic [3:0]   in_enq__RDY;
  logic         out_enq__ENA;
  logic [31:0]  out_enq_v;
  logic [1:0]   out_enq_tag;
  logic         out_enq__RDY;

  int checks = 0;
  int errors = 0;

  vsim_chan_mux #(.WIDTH(32), .CHANNELS(4), .DEPTH(4), .TAGW(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(in_enq__ENA), .in_enq_v(in_enq_v), .in_enq__RDY(in_enq__RDY),
    .out_enq__ENA(out_enq__ENA), .out_enq_v(out_enq_v),
    .out_enq_tag(out_enq_tag), .out_enq__RDY(out_enq__RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          en;
    int          ch;
    logic [31:0] data;
    bit          ordy;
    bit          x_ena;
    logic [31:0] x_v;
    logic [1:0]  x_tag;
    logic [3:0]  x_rdy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] q [4][$];
  logic        pre_ena;
  logic [31:0] pre_v;
  logic [1:0]  pre_tag;
  int          xfers;

  initial begin
    // Single word with 1-cycle latency, then a fill/backpressure/drain on ch0.
    vecs[0]  = '{1, 2, 32'hDEADBEEF, 1, 0, 32'h0,        2'd0, 4'hF};
    vecs[1]  = '{0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 2'd2, 4'hF};
    vecs[2]  = '{0, 0, 32'h0,        1, 0, 32'hDEADBEEF, 2'd2, 4'hF};
    vecs[3]  = '{1, 0, 32'h1,        0, 0, 32'hDEADBEEF, 2'd2, 4'hF};
    vecs[4]  = '{1, 0, 32'h2,        0, 1, 32'h1,        2'd0, 4'hF};
    vecs[5]  = '{1, 0, 32'h3,        0, 1, 32'h1,        2'd0, 4'hF};
    vecs[6]  = '{1, 0, 32'h4,        0, 1, 32'h1,        2'd0, 4'hF};
    vecs[7]  = '{1, 0, 32'h5,        0, 1, 32'h1,        2'd0, 4'hE};
    vecs[8]  = '{1, 0, 32'h6,        0, 1, 32'h1,        2'd0, 4'hE};
    vecs[9]  = '{0, 0, 32'h0,        1, 1, 32'h2,        2'd0, 4'hF};
    vecs[10] = '{0, 0, 32'h0,        1, 1, 32'h3,        2'd0, 4'hF};
    vecs[11] = '{0, 0, 32'h0,        1, 1, 32'h4,        2'd0, 4'hF};
    vecs[12] = '{0, 0, 32'h0,        1, 1, 32'h5,        2'd0, 4'hF};
    vecs[13] = '{0, 0, 32'h0,        1, 0, 32'h5,        2'd0, 4'hF};

    nRST = 1'b0;
    in_enq__ENA = '0;
    in_enq_v = '0;
    out_enq__RDY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ena", out_enq__ENA, 0);
    chk("rst_v",   out_enq_v, 0);
    chk("rst_tag", out_enq_tag, 0);
    chk("rst_rdy", in_enq__RDY, 0);
    nRST = 1'b1;
    #1;
    chk("rel_rdy_low", in_enq__RDY, 0);
    step();
    chk("rel_rdy_high", in_enq__RDY, 4'hF);

    for (int i = 0; i < 14; i++) begin
      in_enq__ENA = '0;
      if (vecs[i].en) begin
        in_enq__ENA[vecs[i].ch] = 1'b1;
        in_enq_v[vecs[i].ch*32 +: 32] = vecs[i].data;
      end
      out_enq__RDY = vecs[i].ordy;
      step();
      in_enq__ENA = '0;
      chk($sformatf("vec%0d_ena", i), out_enq__ENA, vecs[i].x_ena);
      chk($sformatf("vec%0d_v", i),   out_enq_v,    vecs[i].x_v);
      chk($sformatf("vec%0d_tag", i), out_enq_tag,  vecs[i].x_tag);
      chk($sformatf("vec%0d_rdy", i), in_enq__RDY,  vecs[i].x_rdy);
    end

    // Round-robin fairness with three words preloaded in every channel.
    do_reset();
    out_enq__RDY = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_enq__ENA = 4'hF;
      for (int c = 0; c < 4; c++) in_enq_v[c*32 +: 32] = 32'h100 * c + j;
      step();
    end
    in_enq__ENA = '0;
    out_enq__RDY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rr%0d_ena", i), out_enq__ENA, 1);
      chk($sformatf("rr%0d_tag", i), out_enq_tag, i % 4);
      chk($sformatf("rr%0d_v", i),   out_enq_v, 32'h100 * (i % 4) + (i / 4));
      step();
    end
    chk("rr_done_ena", out_enq__ENA, 0);

    // Stall stability with a per-tag scoreboard, ready pattern 1,0,0,1.
    do_reset();
    out_enq__RDY = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_enq__ENA = 4'hF;
      for (int c = 0; c < 4; c++) begin
        in_enq_v[c*32 +: 32] = 32'hA000 + c * 16 + j;
        q[c].push_back(32'hA000 + c * 16 + j);
      end
      step();
    end
    in_enq__ENA = '0;
    xfers = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_enq__RDY = (cyc % 4 == 0) || (cyc % 4 == 3);
      pre_ena = out_enq__ENA;
      pre_v   = out_enq_v;
      pre_tag = out_enq_tag;
      if (pre_ena && out_enq__RDY) begin
        xfers++;
        if (q[pre_tag].size() == 0) chk("stall_dup", 1, 0);
        else chk("stall_order", pre_v, q[pre_tag].pop_front());
      end
      step();
      if (pre_ena && !out_enq__RDY) begin
        chk("stall_hold_ena", out_enq__ENA, 1);
        chk("stall_hold_v",   out_enq_v, pre_v);
        chk("stall_hold_tag", out_enq_tag, pre_tag);
      end
    end
    chk("stall_xfers", xfers, 8);
    chk("stall_end_ena", out_enq__ENA, 0);

    // Full channel popped in the same cycle: stays not-ready, no overflow.
    do_reset();
    out_enq__RDY = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_enq__ENA = 4'b0010;
      in_enq_v[32 +: 32] = 32'h11 + j;
      step();
    end
    chk("full_rdy1", in_enq__RDY[1], 0);
    chk("full_reg_v", out_enq_v, 32'h11);
    out_enq__RDY = 1'b1;
    in_enq__ENA = 4'b0010;
    in_enq_v[32 +: 32] = 32'hBAD;
    #1;
    chk("full_pop_rdy_same", in_enq__RDY[1], 0);
    step();
    in_enq__ENA = '0;
    chk("full_pop_rdy_next", in_enq__RDY[1], 1);
    chk("full_pop_v", out_enq_v, 32'h12);
    for (int j = 3; j <= 5; j++) begin
      step();
      chk($sformatf("full_drain_v%0d", j), out_enq_v, 32'h10 + j);
    end
    step();
    chk("full_drain_ena", out_enq__ENA, 0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    out_enq__RDY = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_enq__ENA = 4'b1010;
      in_enq_v[32 +: 32] = 32'h21 + j;
      in_enq_v[96 +: 32] = 32'h31 + j;
      step();
    end
    in_enq__ENA = '0;
    chk("ar_pre_ena", out_enq__ENA, 1);
    chk("ar_pre_tag", out_enq_tag, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_ena", out_enq__ENA, 0);
    chk("ar_rdy", in_enq__RDY, 0);
    chk("ar_v",   out_enq_v, 0);
    chk("ar_tag", out_enq_tag, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();
    chk("ar_rel_rdy", in_enq__RDY, 4'hF);
    chk("ar_rel_ena", out_enq__ENA, 0);
    out_enq__RDY = 1'b1;
    in_enq__ENA = 4'b1001;
    in_enq_v[0 +: 32]  = 32'h40;
    in_enq_v[96 +: 32] = 32'h43;
    step();
    in_enq__ENA = '0;
    step();
    chk("ar_first_ena", out_enq__ENA, 1);
    chk("ar_first_tag", out_enq_tag, 0);
    chk("ar_first_v",   out_enq_v, 32'h40);
    step();
    chk("ar_second_tag", out_enq_tag, 3);
    chk("ar_second_v",   out_enq_v, 32'h43);
    step();
    chk("ar_empty_ena", out_enq__ENA, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
